// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller and the fetch-side integration.
// redirect_t carries a REDIR_AWIDTH-bit target; the controller's AWIDTH must not exceed it.
package fetch_redirect_ctrl_pkg;

    localparam int REDIR_AWIDTH = 32;

    typedef enum logic {
        REDIR_RUN     = 1'b0,
        REDIR_PENDING = 1'b1
    } redir_state_e;

    typedef struct packed {
        logic                    taken;
        logic                    jump;
        logic [REDIR_AWIDTH-1:0] target;
    } redirect_t;

    // Build a redirect record; fetch only accepts word-aligned targets, so the
    // two low bits are cleared here once for every consumer.
    function automatic redirect_t make_redirect(input logic                    taken,
                                                input logic                    jump,
                                                input logic [REDIR_AWIDTH-1:0] target);
        redirect_t r;
        r.taken  = taken;
        r.jump   = jump;
        r.target = target & ~REDIR_AWIDTH'(3);
        return r;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_load_use_detect.sv
// Combinational load-use hazard comparator: flags a decode instruction that
// reads the destination of a load currently in execute (x0 never hazards).
module load_use_detect #(
    parameter int RWIDTH = 5
) (
    input  logic [RWIDTH-1:0] id_rs1,
    input  logic [RWIDTH-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu      = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect / hazard controller. Issues branch/jump redirects to fetch
// combinationally, inserts load-use bubbles, and parks a redirect that resolves
// during a memory stall until the stall releases.
// Optional macro REDIRECT_PERF_EN adds stall-cycle and flush performance counters.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RWIDTH-1:0] id_rs1_i,
    input  logic [RWIDTH-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_valid_i,
    input  logic [RWIDTH-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              ex_branch_taken_i,
    input  logic              ex_jump_i,
    input  logic [AWIDTH-1:0] ex_target_i,
    input  logic              mem_stall_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              branch_taken_o,
    output logic              jump_o,
    output logic [AWIDTH-1:0] branch_target_o,
    output logic              ex_bubble_o,
    output logic [CWIDTH-1:0] stall_cycles_o,
    output logic [CWIDTH-1:0] flush_count_o
);

    redir_state_e state_q;
    redir_state_e state_d;
    redirect_t    pend_q;
    redirect_t    cur_redir;
    redirect_t    out_redir;
    logic         redir;
    logic         lu;

    assign redir     = ex_valid_i && (ex_branch_taken_i || ex_jump_i);
    assign cur_redir = make_redirect(ex_branch_taken_i, ex_jump_i, REDIR_AWIDTH'(ex_target_i));

    load_use_detect #(
        .RWIDTH (RWIDTH)
    ) u_load_use_detect (
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .id_use_rs1 (id_use_rs1_i),
        .id_use_rs2 (id_use_rs2_i),
        .ex_valid   (ex_valid_i),
        .ex_rd      (ex_rd_i),
        .ex_is_load (ex_is_load_i),
        .lu         (lu)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REDIR_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture a redirect that resolves while memory is stalled; later ex
    // inputs are ignored until it has been issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else if (state_q == REDIR_RUN && mem_stall_i && redir) begin
            pend_q <= cur_redir;
        end
    end

    // Next-state: park on a stalled redirect, release on the first unstalled cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            REDIR_RUN:     if (mem_stall_i && redir) state_d = REDIR_PENDING;
            REDIR_PENDING: if (!mem_stall_i)         state_d = REDIR_RUN;
            default:       state_d = REDIR_RUN;
        endcase
    end

    // Outputs: redirect beats load-use beats idle; everything is quiet in reset
    always_comb begin
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        ex_bubble_o = 1'b0;
        out_redir   = '0;
        if (!rst) begin
            case (state_q)
                REDIR_RUN: begin
                    if (mem_stall_i) begin
                        stall_o = 1'b1;
                    end else if (redir) begin
                        flush_o   = 1'b1;
                        out_redir = cur_redir;
                    end else if (lu) begin
                        stall_o     = 1'b1;
                        ex_bubble_o = 1'b1;
                    end
                end
                REDIR_PENDING: begin
                    if (mem_stall_i) begin
                        stall_o = 1'b1;
                    end else begin
                        // Flush squashes decode, so a coincident load-use is moot.
                        flush_o   = 1'b1;
                        out_redir = pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign branch_taken_o  = out_redir.taken;
    assign jump_o          = out_redir.jump;
    assign branch_target_o = AWIDTH'(out_redir.target);

`ifdef REDIRECT_PERF_EN
    logic [CWIDTH-1:0] stall_cnt_q;
    logic [CWIDTH-1:0] flush_cnt_q;

    // Free-running wrap-around counters of stall and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o) stall_cnt_q <= stall_cnt_q + CWIDTH'(1);
            if (flush_o) flush_cnt_q <= flush_cnt_q + CWIDTH'(1);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed scenarios followed by
// randomized traffic, checked against a queue-based behavioural model.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
    logic        ex_valid_i = 1'b0, ex_is_load_i = 1'b0;
    logic        ex_branch_taken_i = 1'b0, ex_jump_i = 1'b0, mem_stall_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        stall_o, flush_o, branch_taken_o, jump_o, ex_bubble_o;
    logic [31:0] branch_target_o, stall_cycles_o, flush_count_o;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.AWIDTH(32), .RWIDTH(5), .CWIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .ex_valid_i        (ex_valid_i),
        .ex_rd_i           (ex_rd_i),
        .ex_is_load_i      (ex_is_load_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_jump_i         (ex_jump_i),
        .ex_target_i       (ex_target_i),
        .mem_stall_i       (mem_stall_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .branch_taken_o    (branch_taken_o),
        .jump_o            (jump_o),
        .branch_target_o   (branch_target_o),
        .ex_bubble_o       (ex_bubble_o),
        .stall_cycles_o    (stall_cycles_o),
        .flush_count_o     (flush_count_o)
    );

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1, rs2;
        logic        use1, use2, exv;
        logic [4:0]  rd;
        logic        ld, bt, jmp;
        logic [31:0] tgt;
        logic        mstall;
    } stim_t;

    typedef struct packed {
        logic        stall, flush, taken, jump, bubble;
        logic [31:0] target, scyc, fcnt;
    } exp_t;

    typedef struct packed {
        logic        taken, jump;
        logic [31:0] target;
    } held_t;

    exp_t        exp_q[$];
    held_t       held_q[$];
    logic [31:0] m_scyc = '0, m_fcnt = '0;
    int          n_checks = 0, n_pass = 0, n_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, n_cyc, act, req);
    endtask

    // Drive one cycle of stimulus and queue the model's expected response.
    task automatic apply(input stim_t s);
        exp_t  e;
        held_t h;
        logic  redir, lu;
        @(posedge clk); #1;
        rst = s.rst; id_rs1_i = s.rs1; id_rs2_i = s.rs2;
        id_use_rs1_i = s.use1; id_use_rs2_i = s.use2; ex_valid_i = s.exv;
        ex_rd_i = s.rd; ex_is_load_i = s.ld; ex_branch_taken_i = s.bt;
        ex_jump_i = s.jmp; ex_target_i = s.tgt; mem_stall_i = s.mstall;

        redir = s.exv && (s.bt || s.jmp);
        lu    = s.exv && s.ld && (s.rd != 0) &&
                ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        e = '0;
        if (s.rst) begin
            held_q.delete();
            m_scyc = '0;
            m_fcnt = '0;
        end else begin
            e.scyc = m_scyc;
            e.fcnt = m_fcnt;
            if (s.mstall) begin
                e.stall = 1'b1;
                if (held_q.size() == 0 && redir)
                    held_q.push_back('{taken: s.bt, jump: s.jmp, target: {s.tgt[31:2], 2'b00}});
            end else if (held_q.size() > 0) begin
                h = held_q.pop_front();
                e.flush = 1'b1; e.taken = h.taken; e.jump = h.jump; e.target = h.target;
            end else if (redir) begin
                e.flush = 1'b1; e.taken = s.bt; e.jump = s.jmp; e.target = {s.tgt[31:2], 2'b00};
            end else if (lu) begin
                e.stall = 1'b1; e.bubble = 1'b1;
            end
            m_scyc = m_scyc + {31'd0, e.stall};
            m_fcnt = m_fcnt + {31'd0, e.flush};
        end
`ifndef REDIRECT_PERF_EN
        e.scyc = '0;
        e.fcnt = '0;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl{stall,flush,taken,jump,bubble}",
                  {59'd0, stall_o, flush_o, branch_taken_o, jump_o, ex_bubble_o},
                  {59'd0, e.stall, e.flush, e.taken, e.jump, e.bubble});
            check("branch_target", {32'd0, branch_target_o}, {32'd0, e.target});
            check("perf_counters", {stall_cycles_o, flush_count_o}, {e.scyc, e.fcnt});
            n_cyc++;
        end
    end

    initial begin
        stim_t s;
        int    guard;

        // Reset
        s = '0; s.rst = 1'b1;
        apply(s); apply(s);
        // Load-use on x5 via rs1, then a load to x0 that must not stall
        s = '0; s.exv = 1; s.ld = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1; apply(s);
        s = '0; s.exv = 1; s.ld = 1; s.rd = 0; s.rs1 = 0; s.use1 = 1; apply(s);
        s = '0; apply(s);
        // Taken branch to 0x100, then JALR to 0x203 (aligned to 0x200)
        s = '0; s.exv = 1; s.bt = 1; s.tgt = 32'h100; apply(s);
        s = '0; s.exv = 1; s.jmp = 1; s.tgt = 32'h203; apply(s);
        s = '0; apply(s);
        // Branch to 0x80 under a 3-cycle memory stall; later ex inputs ignored
        s = '0; s.exv = 1; s.bt = 1; s.tgt = 32'h80; s.mstall = 1; apply(s);
        s = '0; s.exv = 1; s.jmp = 1; s.tgt = 32'h444; s.mstall = 1; apply(s);
        s = '0; s.mstall = 1; apply(s);
        s = '0; apply(s);
        s = '0; apply(s);
        // Reset while a redirect is parked: nothing is issued afterwards
        s = '0; s.exv = 1; s.bt = 1; s.tgt = 32'h300; s.mstall = 1; apply(s);
        s = '0; s.mstall = 1; apply(s);
        s = '0; s.rst = 1; s.mstall = 1; apply(s);
        s = '0; apply(s);
        s = '0; apply(s);
        // Two load-use stalls plus one redirect after a fresh reset
        s = '0; s.rst = 1; apply(s);
        s = '0; s.exv = 1; s.ld = 1; s.rd = 7; s.rs2 = 7; s.use2 = 1; apply(s);
        s = '0; apply(s);
        s = '0; s.exv = 1; s.ld = 1; s.rd = 3; s.rs1 = 3; s.use1 = 1; apply(s);
        s = '0; s.exv = 1; s.bt = 1; s.tgt = 32'h40; apply(s);
        s = '0; apply(s);

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            s        = '0;
            s.rst    = ($urandom_range(0, 99) == 0);
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.use1   = 1'($urandom_range(0, 1));
            s.use2   = 1'($urandom_range(0, 1));
            s.exv    = ($urandom_range(0, 3) != 0);
            s.rd     = 5'($urandom_range(0, 3));
            s.ld     = 1'($urandom_range(0, 1));
            s.bt     = ($urandom_range(0, 5) == 0);
            s.jmp    = ($urandom_range(0, 7) == 0);
            s.tgt    = $urandom;
            s.mstall = ($urandom_range(0, 3) == 0);
            apply(s);
        end
        s = '0; apply(s);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
